// File: rtl/load_master_pattern.sv
// rtl/load_master_pattern.sv - secret 4-slot master pattern loader with LOADING/LOCKED control
// Optional macro LOAD_MASTER_UNIQUE_SHAPES_EN rejects a shape already held by another loaded slot.
module load_master_pattern (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  LoadShape,
  input  logic [1:0]  ShapeLocation,
  input  logic        loadingShape,
  input  logic        startGame,
  output logic [11:0] masterPattern,
  output logic        masterLoaded
);

  typedef enum logic {
    LOADING = 1'b0,
    LOCKED  = 1'b1
  } state_t;

  state_t     state;
  logic [3:0] slotMask;
  logic [3:0] slotBase;
  logic       shapeValid;
  logic       dupHit;
  logic       writeOk;

  assign slotBase   = {2'b00, ShapeLocation} * 4'd3;
  assign shapeValid = (LoadShape != 3'b000) && (LoadShape != 3'b111);

`ifdef LOAD_MASTER_UNIQUE_SHAPES_EN
  // Rewriting a slot with its own value is not a duplicate, so the target slot is skipped.
  always_comb begin
    dupHit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((2'(i) != ShapeLocation) && slotMask[i] &&
          (masterPattern[3*i +: 3] == LoadShape)) begin
        dupHit = 1'b1;
      end
    end
  end
`else
  assign dupHit = 1'b0;
`endif

  assign writeOk      = loadingShape && shapeValid && !dupHit;
  assign masterLoaded = &slotMask;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= LOADING;
      masterPattern <= 12'h000;
      slotMask      <= 4'b0000;
    end else begin
      case (state)
        LOADING: begin
          // startGame wins over a simultaneous write even when the pattern is incomplete.
          if (startGame) begin
            if (&slotMask) begin
              state <= LOCKED;
            end
          end else if (writeOk) begin
            masterPattern[slotBase +: 3] <= LoadShape;
            slotMask[ShapeLocation]      <= 1'b1;
          end
        end
        LOCKED: begin
          if (startGame) begin
            masterPattern <= 12'h000;
            slotMask      <= 4'b0000;
            state         <= LOADING;
          end
        end
        default: state <= LOADING;
      endcase
    end
  end

endmodule

// File: tb/tb_load_master_pattern.sv
// tb/tb_load_master_pattern.sv - scoreboard bench for load_master_pattern against a slot-array model
module tb_load_master_pattern;

  logic        clock;
  logic        reset;
  logic [2:0]  LoadShape;
  logic [1:0]  ShapeLocation;
  logic        loadingShape;
  logic        startGame;
  logic [11:0] masterPattern;
  logic        masterLoaded;

  load_master_pattern dut (
    .clock         (clock),
    .reset         (reset),
    .LoadShape     (LoadShape),
    .ShapeLocation (ShapeLocation),
    .loadingShape  (loadingShape),
    .startGame     (startGame),
    .masterPattern (masterPattern),
    .masterLoaded  (masterLoaded)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] pat;
    logic        loaded;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  bit   done   = 0;

  // Reference model: the game board as four shape slots plus a lock flag.
  int   mSlot[4];
  bit   mHas[4];
  bit   mLocked;

  function automatic bit allLoaded();
    return mHas[0] && mHas[1] && mHas[2] && mHas[3];
  endfunction

  function automatic void clearBoard();
    for (int i = 0; i < 4; i++) begin
      mSlot[i] = 0;
      mHas[i]  = 0;
    end
  endfunction

  function automatic void modelStep(bit r, bit ld, bit sg, int shp, int loc);
    bit ok;
    if (r) begin
      clearBoard();
      mLocked = 0;
    end else if (mLocked) begin
      if (sg) begin
        clearBoard();
        mLocked = 0;
      end
    end else if (sg) begin
      if (allLoaded()) mLocked = 1;
    end else if (ld && shp >= 1 && shp <= 6) begin
      ok = 1;
`ifdef LOAD_MASTER_UNIQUE_SHAPES_EN
      for (int i = 0; i < 4; i++)
        if (i != loc && mHas[i] && mSlot[i] == shp) ok = 0;
`endif
      if (ok) begin
        mSlot[loc] = shp;
        mHas[loc]  = 1;
      end
    end
  endfunction

  task automatic step(bit r, bit ld, bit sg, int shp, int loc);
    exp_t e;
    reset         = r;
    loadingShape  = ld;
    startGame     = sg;
    LoadShape     = 3'(shp);
    ShapeLocation = 2'(loc);
    modelStep(r, ld, sg, shp, loc);
    e.pat    = 12'(mSlot[3] * 512 + mSlot[2] * 64 + mSlot[1] * 8 + mSlot[0]);
    e.loaded = allLoaded();
    expQ.push_back(e);
    @(negedge clock);
  endtask

  // Monitor: each posedge commits one pushed expectation; compare shortly after it.
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clock);
      #1;
      cycle++;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checks++;
        if (masterPattern !== e.pat) begin
          errors++;
          $display("FAIL masterPattern cycle %0d: got %b expected %b", cycle, masterPattern, e.pat);
        end
        checks++;
        if (masterLoaded !== e.loaded) begin
          errors++;
          $display("FAIL masterLoaded cycle %0d: got %b expected %b", cycle, masterLoaded, e.loaded);
        end
      end
    end
  end

  initial begin
    clearBoard();
    mLocked = 0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    // Single load, then full pattern
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 2, 1);
    step(0, 1, 0, 3, 2);
    step(0, 1, 0, 4, 3);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 5, 2);
    step(0, 1, 0, 3, 2);
    // Partial pattern: invalid shapes and premature startGame
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 2, 1);
    step(0, 1, 0, 0, 3);
    step(0, 1, 0, 7, 3);
    step(0, 1, 1, 3, 2);
    step(0, 1, 0, 3, 2);
    step(0, 1, 0, 4, 3);
    // Lock, ignored load, unlock clears
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 6, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    // Reset while locked and together with a load
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 2, 1);
    step(0, 1, 0, 3, 2);
    step(0, 1, 0, 4, 3);
    step(0, 0, 1, 0, 0);
    step(1, 1, 0, 3, 1);
    step(0, 0, 0, 0, 0);
    // Duplicate shapes across slots
    step(0, 1, 0, 2, 0);
    step(0, 1, 0, 2, 1);
    step(0, 1, 0, 2, 0);
    step(0, 0, 0, 0, 0);
    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 11) == 0),
           int'($urandom_range(0, 7)),
           int'($urandom_range(0, 3)));
    end
    step(0, 0, 0, 0, 0);
    @(negedge clock);
    @(negedge clock);
    done = 1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
